parity_frame_tx: RTL
====================

Name: parity_frame_tx

Overview:
- Transmit-side counterpart of the team's parity checker.
- Accepts a parallel DATA_W-bit word with a parity mode over a valid/ready handshake.
- Computes the parity bit so the {data, parity} frame has even (mode=0) or odd (mode=1) total ones.
- Serialises start, data (LSB first), parity and stop bits onto a single line for the receiving checker.

Parameters:
- DATA_W, 3, data word width in bits; must be >= 1.
- BIT_CYCLES, 1, clock cycles per serial bit period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset; rst=0 at a rising edge resets the block.
- data_in  input  DATA_W  word to transmit; sampled only on handshake.
- mode  input  1  0 = even frame parity, 1 = odd frame parity; sampled only on handshake.
- valid_in  input  1  word/mode available.
- ready_out  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles high.
- busy  output  1  frame in progress (START..STOP).
- parity_out  output  1  parity bit of the current/last accepted frame.
- done  output  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
- Reset (rst=0 at edge): state=IDLE, ready_out=1, tx_out=1, busy=0, parity_out=0, done=0, counters cleared. Reset wins over any simultaneous handshake.
- Reset mid-frame: the frame is aborted. tx_out=1 from the next edge. No done pulse.
- Handshake: a transfer occurs at an edge where valid_in=1 and ready_out=1. ready_out=1 only in IDLE.
- valid_in while busy is ignored, not queued. data_in and mode changes during a frame have no effect.
- On transfer:
  - Latch data into the shift register.
  - parity_out <= (^data_in) ^ mode. This gives even total ones when mode=0 and odd total ones when mode=1.
  - Enter START; busy=1, ready_out=0.
- State machine (all outputs registered):
  - IDLE: tx_out=1.
  - START: tx_out=0 for BIT_CYCLES clocks.
  - DATA: tx_out=data bit i for i=0..DATA_W-1, BIT_CYCLES clocks each; bit_cnt counts 0..DATA_W-1.
  - PARITY: tx_out=parity_out for BIT_CYCLES clocks.
  - STOP: tx_out=1 for BIT_CYCLES clocks, then return to IDLE with done=1 for exactly that first IDLE cycle.
- Timing:
  - tx_out falls on the first clock after the handshake edge.
  - Frame length is (DATA_W+3)*BIT_CYCLES clocks.
- Back-to-back: ready_out=1 in the done cycle. A handshake there starts the next frame, giving a minimum inter-frame gap of 1 clock at tx_out=1.
- Counters:
  - cyc_cnt width $clog2(BIT_CYCLES) (min 1); wraps to 0 at BIT_CYCLES-1 and advances state/bit.
  - bit_cnt width $clog2(DATA_W) (min 1); no overflow beyond DATA_W-1.
- parity_out holds its value after the frame until the next transfer.

Decomposition:
- Shared package parity_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}.
  - Constants MODE_EVEN=1'b0, MODE_ODD=1'b1, LINE_IDLE=1'b1, START_BIT=1'b0.
  - Both this block and the checker import the mode constants.
- One sub-module bit_timer (cyc_cnt plus a tick output on the terminal count). Parameterised by BIT_CYCLES; cleared on handshake and on reset.

Test Plan:
- DATA_W=3, BIT_CYCLES=1, data_in=3'b101, mode=0 -> parity_out=0; tx_out after handshake = 0,1,0,1,0,1; done pulses on the 6th clock after the handshake.
- data_in=3'b111, mode=0 -> parity_out=1, tx_out = 0,1,1,1,1,1. Same data with mode=1 -> parity_out=0, tx_out = 0,1,1,1,0,1.
- data_in=3'b000, mode=1 -> parity_out=1. Feed the frame's data+parity into the checker model with the same mode -> frame parity verified OK. Repeat for all 8 data values x 2 modes.
- BIT_CYCLES=4, data_in=3'b110, mode=0 -> each level held 4 clocks; frame 24 clocks; sequence 0,0,1,1,0,1 per bit period.
- Assert valid_in continuously with changing data:
  - ready_out=0 during the frame.
  - Second word accepted in the done cycle; exactly 1 idle-high clock between the frames.
  - Mid-frame data changes not transmitted.
- rst=0 during DATA bit 1 -> next edge tx_out=1, busy=0, ready_out=1, parity_out=0, no done. The next handshake transmits a clean full frame.

Source files
------------

// File: rtl/parity_pkg.sv
// ============================================================
// parity_pkg : shared state encoding and line/mode constants for the parity transmitter and checker
// Revision 1.0
// ============================================================
`default_nettype none

package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
// ============================================================
// bit_timer : counts clocks within one serial bit period and flags the last one
// Revision 1.0
// ============================================================
`default_nettype none

module bit_timer
  import parity_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cyc_cnt_q;
  logic [CW-1:0] cyc_cnt_d;

  assign tick_o = run_i && (cyc_cnt_q == C_LAST);

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (clr_i) begin
      cyc_cnt_d = '0;
    end else if (run_i) begin
      cyc_cnt_d = tick_o ? '0 : cyc_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/parity_frame_tx.sv
// ============================================================
// parity_frame_tx : serialises start, data (LSB first), parity and stop bits from a valid/ready word
// Revision 1.0
// ============================================================
`default_nettype none

module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mode,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              parity_out,
  output logic              done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BW-1:0]     bit_cnt_q;
  logic              ready_q;
  logic              tx_q;
  logic              busy_q;
  logic              parity_q;
  logic              done_q;

  logic w_hs;
  logic w_tick;

  assign w_hs       = valid_in && ready_q;
  assign ready_out  = ready_q;
  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign parity_out = parity_q;
  assign done       = done_q;

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_hs),
    .run_i  (busy_q),
    .tick_o (w_tick)
  );

  // tx_q is loaded with the level of the state being entered, so the line changes on the transition edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b1;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      parity_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_hs) begin
            shift_q   <= data_in;
            parity_q  <= (^data_in) ^ (mode == MODE_ODD);
            bit_cnt_q <= '0;
            state_q   <= START;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (bit_cnt_q == C_LAST_BIT) begin
              state_q <= PARITY;
              tx_q    <= parity_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            state_q <= STOP;
            tx_q    <= LINE_IDLE;
          end
        end
        STOP: begin
          if (w_tick) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
